// File: rtl/lsq_multi_pkg.sv
// rtl/lsq_multi_pkg.sv - shared constants, FSM states and helpers for the load/store queue
// Holds the memory op encodings (10..17), the default MMIO base address,
// the issue FSM state encoding and small width/extension/mask helpers.
package lsq_multi_pkg;

    localparam logic [5:0] OP_LB  = 6'd10;
    localparam logic [5:0] OP_LH  = 6'd11;
    localparam logic [5:0] OP_LW  = 6'd12;
    localparam logic [5:0] OP_LBU = 6'd13;
    localparam logic [5:0] OP_LHU = 6'd14;
    localparam logic [5:0] OP_SB  = 6'd15;
    localparam logic [5:0] OP_SH  = 6'd16;
    localparam logic [5:0] OP_SW  = 6'd17;

    localparam logic [31:0] MMIO_BASE_DEF = 32'h0003_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } lsq_state_e;

    function automatic logic op_is_store(input logic [5:0] op);
        return (op >= OP_SB);
    endfunction

    function automatic logic [2:0] op_width(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 3'd1;
            OP_LH, OP_LHU, OP_SH: return 3'd2;
            default:              return 3'd4;
        endcase
    endfunction

    function automatic logic [31:0] ld_extend(input logic [5:0] op, input logic [31:0] d);
        case (op)
            OP_LB:   return {{24{d[7]}}, d[7:0]};
            OP_LH:   return {{16{d[15]}}, d[15:0]};
            OP_LBU:  return {24'd0, d[7:0]};
            OP_LHU:  return {16'd0, d[15:0]};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] st_mask(input logic [5:0] op, input logic [31:0] d);
        case (op)
            OP_SB:   return {24'd0, d[7:0]};
            OP_SH:   return {16'd0, d[15:0]};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/lsq_wakeup.sv
// rtl/lsq_wakeup.sv - combinational tag match of one operand against the broadcast channels
// Ports: tag (operand producer tag), cdb_valid/cdb_id/cdb_value (packed
// broadcast channels), ld_valid/ld_id/ld_value (registered load result
// bypass), hit/value (match flag and the selected value).
module lsq_wakeup #(
    parameter int ROB_BITS = 4,
    parameter int CDB_N    = 2
) (
    input  logic [ROB_BITS-1:0]       tag,
    input  logic [CDB_N-1:0]          cdb_valid,
    input  logic [CDB_N*ROB_BITS-1:0] cdb_id,
    input  logic [CDB_N*32-1:0]       cdb_value,
    input  logic                      ld_valid,
    input  logic [ROB_BITS-1:0]       ld_id,
    input  logic [31:0]               ld_value,
    output logic                      hit,
    output logic [31:0]               value
);

    always_comb begin
        hit   = 1'b0;
        value = 32'd0;
        // Walk from the highest channel down so the lowest matching index is the last write.
        for (int c = CDB_N - 1; c >= 0; c--) begin
            if (cdb_valid[c] && (cdb_id[c*ROB_BITS +: ROB_BITS] == tag)) begin
                hit   = 1'b1;
                value = cdb_value[c*32 +: 32];
            end
        end
        if (!hit && ld_valid && (ld_id == tag)) begin
            hit   = 1'b1;
            value = ld_value;
        end
    end

endmodule

// File: rtl/lsq_multi.sv
// rtl/lsq_multi.sv - parametrised in-order-issue load/store queue with CDB snooping and flush
// Ports: clk_in/rst_in (sync active-high)/rdy_in (global enable); alloc_* dispatch
// write; cdb_* broadcast snoop; rob_head_id; flush; mem_* memctrl request and
// response; ld_* load result; st_* store completion; count occupancy.
// Optional LSQ_MISALIGN_CHK_EN: misaligned head entries are popped without
// issuing and reported on exc_valid/exc_id.
module lsq_multi
    import lsq_multi_pkg::*;
#(
    parameter int          DEPTH     = 16,
    parameter int          ROB_BITS  = 4,
    parameter int          CDB_N     = 2,
    parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEF
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic                      alloc_valid,
    output logic                      alloc_ready,
    input  logic [5:0]                alloc_op,
    input  logic [31:0]               alloc_vj,
    input  logic [31:0]               alloc_vk,
    input  logic [31:0]               alloc_imm,
    input  logic [ROB_BITS-1:0]       alloc_qj,
    input  logic [ROB_BITS-1:0]       alloc_qk,
    input  logic                      alloc_j,
    input  logic                      alloc_k,
    input  logic [ROB_BITS-1:0]       alloc_rob_id,
    input  logic [CDB_N-1:0]          cdb_valid,
    input  logic [CDB_N*ROB_BITS-1:0] cdb_id,
    input  logic [CDB_N*32-1:0]       cdb_value,
    input  logic [ROB_BITS-1:0]       rob_head_id,
    input  logic                      flush,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [2:0]                mem_width,
    output logic [31:0]               mem_addr,
    output logic [31:0]               mem_wdata,
    input  logic                      mem_ack,
    input  logic                      mem_rvalid,
    input  logic [31:0]               mem_rdata,
    output logic                      ld_valid,
    output logic [ROB_BITS-1:0]       ld_id,
    output logic [31:0]               ld_value,
    output logic                      st_valid,
    output logic [ROB_BITS-1:0]       st_id,
    output logic [$clog2(DEPTH):0]    count
`ifdef LSQ_MISALIGN_CHK_EN
    ,
    output logic                      exc_valid,
    output logic [ROB_BITS-1:0]       exc_id
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DEPTH-1:0]    busy_q, busy_d, j_q, j_d, k_q, k_d;
    logic [5:0]          op_q [DEPTH], op_d [DEPTH];
    logic [31:0]         vj_q [DEPTH], vj_d [DEPTH], vk_q [DEPTH], vk_d [DEPTH];
    logic [31:0]         imm_q[DEPTH], imm_d[DEPTH];
    logic [ROB_BITS-1:0] qj_q [DEPTH], qj_d [DEPTH], qk_q [DEPTH], qk_d [DEPTH];
    logic [ROB_BITS-1:0] rob_q[DEPTH], rob_d[DEPTH];
    logic [PW-1:0]       head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]       count_q, count_d;
    lsq_state_e          state_q, state_d;
    logic                ld_valid_q, ld_valid_d, st_valid_q, st_valid_d;
    logic [ROB_BITS-1:0] ld_id_q, ld_id_d, st_id_q, st_id_d, ld_rob_q, ld_rob_d;
    logic [31:0]         ld_value_q, ld_value_d;
    logic [5:0]          ld_op_q, ld_op_d;

    logic [DEPTH-1:0]    hit_j, hit_k;
    logic [31:0]         wval_j[DEPTH], wval_k[DEPTH];
    logic                a_hit_j, a_hit_k;
    logic [31:0]         a_val_j, a_val_k;

    logic [5:0]          h_op;
    logic [31:0]         h_addr;
    logic                h_store, h_ready, can_issue, issue_ok, fire, pop, push, exc_pop;

    for (genvar i = 0; i < DEPTH; i++) begin : g_wake
        lsq_wakeup #(.ROB_BITS(ROB_BITS), .CDB_N(CDB_N)) u_j (
            .tag(qj_q[i]), .cdb_valid(cdb_valid), .cdb_id(cdb_id), .cdb_value(cdb_value),
            .ld_valid(ld_valid_q), .ld_id(ld_id_q), .ld_value(ld_value_q),
            .hit(hit_j[i]), .value(wval_j[i]));
        lsq_wakeup #(.ROB_BITS(ROB_BITS), .CDB_N(CDB_N)) u_k (
            .tag(qk_q[i]), .cdb_valid(cdb_valid), .cdb_id(cdb_id), .cdb_value(cdb_value),
            .ld_valid(ld_valid_q), .ld_id(ld_id_q), .ld_value(ld_value_q),
            .hit(hit_k[i]), .value(wval_k[i]));
    end

    // Operands arriving on a broadcast in the allocation cycle are captured directly.
    lsq_wakeup #(.ROB_BITS(ROB_BITS), .CDB_N(CDB_N)) u_alloc_j (
        .tag(alloc_qj), .cdb_valid(cdb_valid), .cdb_id(cdb_id), .cdb_value(cdb_value),
        .ld_valid(ld_valid_q), .ld_id(ld_id_q), .ld_value(ld_value_q),
        .hit(a_hit_j), .value(a_val_j));
    lsq_wakeup #(.ROB_BITS(ROB_BITS), .CDB_N(CDB_N)) u_alloc_k (
        .tag(alloc_qk), .cdb_valid(cdb_valid), .cdb_id(cdb_id), .cdb_value(cdb_value),
        .ld_valid(ld_valid_q), .ld_id(ld_id_q), .ld_value(ld_value_q),
        .hit(a_hit_k), .value(a_val_k));

    assign h_op      = op_q[head_q];
    assign h_addr    = vj_q[head_q] + imm_q[head_q];
    assign h_store   = op_is_store(h_op);
    assign h_ready   = busy_q[head_q] & j_q[head_q] & k_q[head_q];
    // Plain loads go speculatively; stores and MMIO loads wait for their ROB entry to be oldest.
    assign can_issue = h_ready && ((!h_store && (h_addr < MMIO_BASE)) || (rob_head_id == rob_q[head_q]));

`ifdef LSQ_MISALIGN_CHK_EN
    logic                misal, exc_valid_q;
    logic [ROB_BITS-1:0] exc_id_q;
    assign misal    = ((op_width(h_op) == 3'd2) && h_addr[0]) ||
                      ((op_width(h_op) == 3'd4) && (h_addr[1:0] != 2'b00));
    assign issue_ok = can_issue && !misal;
    assign exc_pop  = (state_q == ST_IDLE) && can_issue && misal && !flush;
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            exc_valid_q <= 1'b0;
            exc_id_q    <= '0;
        end else if (rdy_in) begin
            exc_valid_q <= exc_pop;
            exc_id_q    <= exc_pop ? rob_q[head_q] : exc_id_q;
        end
    end
    assign exc_valid = exc_valid_q;
    assign exc_id    = exc_id_q;
`else
    assign issue_ok = can_issue;
    assign exc_pop  = 1'b0;
`endif

    // Output process: the request is raised straight from IDLE so it appears the cycle after allocation.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_width = 3'd0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        if (rdy_in && !flush && ((state_q == ST_REQ) || ((state_q == ST_IDLE) && issue_ok))) begin
            mem_req   = 1'b1;
            mem_we    = h_store;
            mem_width = op_width(h_op);
            mem_addr  = h_addr;
            mem_wdata = h_store ? st_mask(h_op, vk_q[head_q]) : 32'd0;
        end
    end

    assign fire        = mem_req & mem_ack;
    assign pop         = fire | exc_pop;
    assign alloc_ready = (count_q != FULL);
    assign push        = alloc_valid && alloc_ready && !flush;

    // Next-state process.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (issue_ok) state_d = !fire ? ST_REQ : (h_store ? ST_IDLE : ST_WAIT);
            ST_REQ:   if (fire) state_d = h_store ? ST_IDLE : ST_WAIT;
            ST_WAIT,
            ST_DRAIN: if (mem_rvalid) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        // A load in flight when flushed still owes one response; swallow it in DRAIN.
        if (flush) begin
            state_d = (((state_q == ST_WAIT) || (state_q == ST_DRAIN)) && !mem_rvalid) ? ST_DRAIN : ST_IDLE;
        end
    end

    always_comb begin
        busy_d = busy_q;  j_d = j_q;  k_d = k_q;
        op_d = op_q;  vj_d = vj_q;  vk_d = vk_q;  imm_d = imm_q;
        qj_d = qj_q;  qk_d = qk_q;  rob_d = rob_q;
        ld_valid_d = 1'b0;  ld_id_d = ld_id_q;  ld_value_d = ld_value_q;
        st_valid_d = 1'b0;  st_id_d = st_id_q;
        ld_op_d = ld_op_q;  ld_rob_d = ld_rob_q;

        for (int i = 0; i < DEPTH; i++) begin
            if (busy_q[i] && !j_q[i] && hit_j[i]) begin
                j_d[i]  = 1'b1;
                vj_d[i] = wval_j[i];
            end
            if (busy_q[i] && !k_q[i] && hit_k[i]) begin
                k_d[i]  = 1'b1;
                vk_d[i] = wval_k[i];
            end
        end

        if (pop) busy_d[head_q] = 1'b0;
        if (fire && h_store) begin
            st_valid_d = 1'b1;
            st_id_d    = rob_q[head_q];
        end
        // The entry leaves the queue at the ack, so keep what the response needs.
        if (fire && !h_store) begin
            ld_op_d  = h_op;
            ld_rob_d = rob_q[head_q];
        end
        if ((state_q == ST_WAIT) && mem_rvalid && !flush) begin
            ld_valid_d = 1'b1;
            ld_id_d    = ld_rob_q;
            ld_value_d = ld_extend(ld_op_q, mem_rdata);
        end

        if (push) begin
            busy_d[tail_q] = 1'b1;
            op_d[tail_q]   = alloc_op;
            imm_d[tail_q]  = alloc_imm;
            qj_d[tail_q]   = alloc_qj;
            qk_d[tail_q]   = alloc_qk;
            rob_d[tail_q]  = alloc_rob_id;
            j_d[tail_q]    = alloc_j | a_hit_j;
            k_d[tail_q]    = alloc_k | a_hit_k;
            vj_d[tail_q]   = alloc_j ? alloc_vj : a_val_j;
            vk_d[tail_q]   = alloc_k ? alloc_vk : a_val_k;
        end

        head_d  = head_q + PW'(pop);
        tail_d  = tail_q + PW'(push);
        count_d = count_q + CW'(push) - CW'(pop);

        if (flush) begin
            busy_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= ST_IDLE;
            busy_q     <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            ld_valid_q <= 1'b0;
            ld_id_q    <= '0;
            ld_value_q <= '0;
            st_valid_q <= 1'b0;
            st_id_q    <= '0;
            ld_op_q    <= '0;
            ld_rob_q   <= '0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            ld_valid_q <= ld_valid_d;
            ld_id_q    <= ld_id_d;
            ld_value_q <= ld_value_d;
            st_valid_q <= st_valid_d;
            st_id_q    <= st_id_d;
            ld_op_q    <= ld_op_d;
            ld_rob_q   <= ld_rob_d;
        end
    end

    // Entry payload is qualified by busy, so it needs no reset.
    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            j_q   <= j_d;
            k_q   <= k_d;
            op_q  <= op_d;
            vj_q  <= vj_d;
            vk_q  <= vk_d;
            imm_q <= imm_d;
            qj_q  <= qj_d;
            qk_q  <= qk_d;
            rob_q <= rob_d;
        end
    end

    assign ld_valid = ld_valid_q;
    assign ld_id    = ld_id_q;
    assign ld_value = ld_value_q;
    assign st_valid = st_valid_q;
    assign st_id    = st_id_q;
    assign count    = count_q;

endmodule
